debounce_sync: RTL and testbench
================================

# debounce_sync

Synchronizing debouncer that conditions a raw asynchronous input (push-button, switch, external strobe) before it drives the `d` or `set` pin of the downstream positive-edge flop stages. It resynchronizes the input into `clk`, filters bounce with a stability counter and a four-state FSM, and presents a clean level plus single-cycle rise and fall pulses.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a level change; must be ≥2.
- `SYNC_STAGES`, default 2: number of synchronizer flops; must be ≥2.
- `CNT_W`, default `$clog2(STABLE_CYCLES)`: width of the stability counter.

Ports:
- `clk`, input, 1: clock; all logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `din`, input, 1: raw asynchronous input.
- `en`, input, 1: filter enable, synchronous.
- `dout`, output, 1: debounced level, registered.
- `rise`, output, 1: one-cycle pulse when `dout` goes 0→1.
- `fall`, output, 1: one-cycle pulse when `dout` goes 1→0.
- `busy`, output, 1: high while the FSM is in a WAIT state.
- `glitch_cnt`, output, 8: present only with `DEBOUNCE_GLITCH_CNT_EN`; see Configuration.

## Operation
- Synchronizer: `din` passes through a `SYNC_STAGES`-deep flop chain; the last stage is `s`. The chain runs regardless of `en`.
- FSM states and transitions:
  - STABLE_LO (reset state, `dout`=0): if `en` and `s`=1, go to WAIT_HI and clear `cnt`.
  - WAIT_HI: if `s`=0, return to STABLE_LO (this is a glitch). Else if `cnt`==`STABLE_CYCLES`-1, go to STABLE_HI, set `dout`=1 and `rise`=1. Otherwise increment `cnt`.
  - STABLE_HI (`dout`=1): if `en` and `s`=0, go to WAIT_LO and clear `cnt`.
  - WAIT_LO: mirror of WAIT_HI, leading to STABLE_LO with `dout`=0 and `fall`=1.
- `en`=0:
  - In a WAIT state, the FSM returns to the STABLE state of the current `dout` on the next edge and clears `cnt`.
  - No pulses are generated, and this is not counted as a glitch.
- Outputs:
  - `rise` and `fall` are registered and high for exactly one cycle, in the same cycle `dout` first shows the new value.
  - `rise` and `fall` are never high together.
  - `busy` is decoded directly from the state register.
- `cnt` never exceeds `STABLE_CYCLES`-1 and never wraps.

## Timing
- Reset (`rst`=0, asynchronous): state becomes STABLE_LO, and the sync chain, `cnt`, `dout`, `rise`, `fall`, `busy` and `glitch_cnt` all become 0. This takes effect immediately, mid-operation included.
- Latency: `din` must be held for `SYNC_STAGES`+`STABLE_CYCLES`+1 rising edges, counted from the first edge that samples the new value. `dout`, `rise` and `fall` update on that edge.
- Defaults give 7 edges.
- Minimum rejected pulse: any `s` excursion shorter than `STABLE_CYCLES`+1 cycles produces no change on `dout`.
- Simultaneous events:
  - `en` falling on the accepting edge: `en`=0 wins; no transition occurs.
  - `s` reverting on the accepting edge: treated as a glitch.

## Configuration
- `DEBOUNCE_GLITCH_CNT_EN` defined:
  - Adds an 8-bit `glitch_cnt` output port and register.
  - `glitch_cnt` increments by 1 each time a WAIT state aborts because `s` reverted.
  - It saturates at 255 and clears only on reset.
- Not defined: the port and register are absent, and all other behaviour is identical.

## Test plan
All scenarios use `STABLE_CYCLES`=4, `SYNC_STAGES`=2 and `en`=1 unless noted.
- Reset: assert `rst`=0 mid-WAIT_HI, between clock edges → `dout`, `rise`, `fall` and `busy` go to 0 immediately; after release, a held `din`=1 again takes 7 edges to set `dout`.
- Clean rise: `din` goes 0→1 before edge 1 and is held → `busy` is high from edge 3; `dout`=1 and `rise`=1 for exactly one cycle at edge 7; `fall` stays 0.
- Clean fall: from `dout`=1, drive `din`=0 and hold → `dout`=0 and `fall`=1 for one cycle, 7 edges later.
- Bounce: `din`=1 for 3 cycles, then 0 → `dout` stays 0, `busy` pulses then clears, no `rise`; with the macro, `glitch_cnt`=1.
- Enable: `din`=1 held, drop `en` after edge 4 → `busy`=0 on the next edge, `dout` stays 0, `glitch_cnt` is unchanged; restoring `en` restarts the count, with `dout`=1 at `STABLE_CYCLES`+1 edges after the edge that samples `en`=1.
- Saturation (macro): 300 bounce pulses → `glitch_cnt`=255.

Source files
------------

// File: rtl/debounce_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : debounce_sync
//  Description : Synchronizing debouncer. Resynchronizes a raw asynchronous
//                input into clk, filters bounce with a stability counter and
//                a four-state FSM, and presents a registered clean level plus
//                single-cycle rise/fall pulses.
//                Optional feature macro: DEBOUNCE_GLITCH_CNT_EN adds an 8-bit
//                saturating glitch_cnt output counting aborted WAIT states.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_sync #(
   parameter int STABLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   input  logic       en,
   output logic       dout,
   output logic       rise,
   output logic       fall,
   output logic       busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [7:0] glitch_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_STABLE_LO = 2'd0,
      ST_WAIT_HI   = 2'd1,
      ST_STABLE_HI = 2'd2,
      ST_WAIT_LO   = 2'd3
   } state_t;

   // Terminal count: the WAIT state accepts on the edge after cnt reaches it.
   localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;
   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   r_dout;
   logic                   w_dout_nxt;
   logic                   r_rise;
   logic                   w_rise_nxt;
   logic                   r_fall;
   logic                   w_fall_nxt;
   logic                   w_glitch;

   // Synchronizer chain; runs independently of the filter enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_sync <= '0;
      else      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_STABLE_LO;
         r_cnt   <= '0;
         r_dout  <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dout  <= w_dout_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   // Next-state logic: a dropped enable beats both glitch and acceptance.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dout_nxt  = r_dout;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      w_glitch    = 1'b0;
      case (r_state)
         ST_STABLE_LO: begin
            if (en && w_s) begin
               w_state_nxt = ST_WAIT_HI;
               w_cnt_nxt   = '0;
            end
         end
         ST_WAIT_HI: begin
            if (!en) begin
               w_state_nxt = ST_STABLE_LO;
               w_cnt_nxt   = '0;
            end else if (!w_s) begin
               w_state_nxt = ST_STABLE_LO;
               w_cnt_nxt   = '0;
               w_glitch    = 1'b1;
            end else if (r_cnt == c_cnt_max) begin
               w_state_nxt = ST_STABLE_HI;
               w_cnt_nxt   = '0;
               w_dout_nxt  = 1'b1;
               w_rise_nxt  = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         ST_STABLE_HI: begin
            if (en && !w_s) begin
               w_state_nxt = ST_WAIT_LO;
               w_cnt_nxt   = '0;
            end
         end
         ST_WAIT_LO: begin
            if (!en) begin
               w_state_nxt = ST_STABLE_HI;
               w_cnt_nxt   = '0;
            end else if (w_s) begin
               w_state_nxt = ST_STABLE_HI;
               w_cnt_nxt   = '0;
               w_glitch    = 1'b1;
            end else if (r_cnt == c_cnt_max) begin
               w_state_nxt = ST_STABLE_LO;
               w_cnt_nxt   = '0;
               w_dout_nxt  = 1'b0;
               w_fall_nxt  = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_STABLE_LO;
            w_cnt_nxt   = '0;
            w_dout_nxt  = 1'b0;
         end
      endcase
   end

   assign dout = r_dout;
   assign rise = r_rise;
   assign fall = r_fall;
   assign busy = (r_state == ST_WAIT_HI) || (r_state == ST_WAIT_LO);

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] r_glitch_cnt;

   // Saturating count of WAIT states aborted by the input reverting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                   r_glitch_cnt <= 8'd0;
      else if (w_glitch && r_glitch_cnt != 8'hFF) r_glitch_cnt <= r_glitch_cnt + 8'd1;
   end

   assign glitch_cnt = r_glitch_cnt;
`else
   logic w_unused_glitch;
   assign w_unused_glitch = w_glitch;
`endif

endmodule
`default_nettype wire

// File: tb/tb_debounce_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_debounce_sync
//  Description : Self-checking bench for debounce_sync (STABLE_CYCLES=4,
//                SYNC_STAGES=2). Honours DEBOUNCE_GLITCH_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_sync;

   localparam int SC = 4;
   localparam int SS = 2;

   logic clk;
   logic rst;
   logic din;
   logic en;
   logic dout;
   logic rise;
   logic fall;
   logic busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] glitch_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   debounce_sync #(
      .STABLE_CYCLES (SC),
      .SYNC_STAGES   (SS)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .en         (en),
      .dout       (dout),
      .rise       (rise),
      .fall       (fall),
      .busy       (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_cnt (glitch_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the value the filter sees is din delayed by SS edges;
   // dout flips once the filter has seen SC+1 consecutive enabled edges that
   // disagree with dout. An enabled agreeing edge that interrupts such a run
   // is a glitch; a disabled edge simply discards the run.
   logic hist[$];
   int   m_run;
   logic m_dout, m_rise, m_fall, m_busy;
   int   m_glitch;

   function automatic void model_reset();
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back(1'b0);
      m_run = 0; m_dout = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
      m_busy = 1'b0; m_glitch = 0;
   endfunction

   function automatic void model_step();
      logic s_seen;
      s_seen = hist.pop_front();
      hist.push_back(din);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (!en) begin
         m_run = 0;
      end else if (s_seen != m_dout) begin
         m_run = m_run + 1;
         if (m_run == SC + 1) begin
            m_dout = s_seen;
            m_rise = s_seen;
            m_fall = !s_seen;
            m_run  = 0;
         end
      end else begin
         if (m_run > 0 && m_glitch < 255) m_glitch = m_glitch + 1;
         m_run = 0;
      end
      m_busy = (m_run > 0);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else      model_step();
   end

   task automatic test_reset();
      logic [3:0] exp;
      rst = 1'b0; din = 1'b0; en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({dout, rise, fall, busy} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_hold: dout/rise/fall/busy=%b required 0000", {dout, rise, fall, busy});
      end
      @(negedge clk); rst = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(negedge clk); din = 1'b1;
         @(posedge clk); #1;
      end
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_pre_busy: busy=%b required 1", busy);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({dout, rise, fall, busy} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_async: dout/rise/fall/busy=%b required 0000", {dout, rise, fall, busy});
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      n_checks++;
      if (glitch_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_glitch: glitch_cnt=%0d required 0", glitch_cnt);
      end
`endif
      @(negedge clk); rst = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk); #1;
         exp = {1'(e >= 7), 1'(e == 7), 1'b0, 1'(e >= 3 && e <= 6)};
         n_checks++;
         if ({dout, rise, fall, busy} !== exp) begin
            n_fail++;
            $display("FAIL reset_relatch e%0d: dout/rise/fall/busy=%b required %b", e, {dout, rise, fall, busy}, exp);
         end
         n_checks++;
         if ({dout, rise, fall, busy} !== {m_dout, m_rise, m_fall, m_busy}) begin
            n_fail++;
            $display("FAIL reset_model e%0d: got %b required %b", e, {dout, rise, fall, busy}, {m_dout, m_rise, m_fall, m_busy});
         end
      end
   endtask

   task automatic test_clean_fall();
      logic [3:0] exp;
      for (int e = 1; e <= 9; e++) begin
         @(negedge clk); din = 1'b0;
         @(posedge clk); #1;
         exp = {1'(e < 7), 1'b0, 1'(e == 7), 1'(e >= 3 && e <= 6)};
         n_checks++;
         if ({dout, rise, fall, busy} !== exp) begin
            n_fail++;
            $display("FAIL clean_fall e%0d: dout/rise/fall/busy=%b required %b", e, {dout, rise, fall, busy}, exp);
         end
      end
   endtask

   task automatic test_bounce();
      logic [3:0] exp;
      for (int e = 1; e <= 10; e++) begin
         @(negedge clk); din = 1'(e <= 3);
         @(posedge clk); #1;
         exp = {1'b0, 1'b0, 1'b0, 1'(e >= 3 && e <= 5)};
         n_checks++;
         if ({dout, rise, fall, busy} !== exp) begin
            n_fail++;
            $display("FAIL bounce e%0d: dout/rise/fall/busy=%b required %b", e, {dout, rise, fall, busy}, exp);
         end
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      n_checks++;
      if (glitch_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL bounce_glitch: glitch_cnt=%0d required 1", glitch_cnt);
      end
`endif
   endtask

   task automatic test_clean_rise();
      logic [3:0] exp;
      for (int e = 1; e <= 9; e++) begin
         @(negedge clk); din = 1'b1;
         @(posedge clk); #1;
         exp = {1'(e >= 7), 1'(e == 7), 1'b0, 1'(e >= 3 && e <= 6)};
         n_checks++;
         if ({dout, rise, fall, busy} !== exp) begin
            n_fail++;
            $display("FAIL clean_rise e%0d: dout/rise/fall/busy=%b required %b", e, {dout, rise, fall, busy}, exp);
         end
      end
   endtask

   task automatic test_enable();
      logic [3:0] exp;
      din = 1'b0; en = 1'b1;
      repeat (10) @(negedge clk);
      // Enable dropped mid-wait, then restored.
      for (int e = 1; e <= 14; e++) begin
         @(negedge clk); din = 1'b1; en = !(e >= 5 && e <= 8);
         @(posedge clk); #1;
         exp = {1'(e >= 13), 1'(e == 13), 1'b0, 1'((e >= 3 && e <= 4) || (e >= 9 && e <= 12))};
         n_checks++;
         if ({dout, rise, fall, busy} !== exp) begin
            n_fail++;
            $display("FAIL enable_restart e%0d: dout/rise/fall/busy=%b required %b", e, {dout, rise, fall, busy}, exp);
         end
      end
      // Enable low exactly on the accepting edge.
      for (int f = 1; f <= 13; f++) begin
         @(negedge clk); din = 1'b0; en = (f != 7);
         @(posedge clk); #1;
         exp = {1'(f < 12), 1'b0, 1'(f == 12), 1'((f >= 3 && f <= 6) || (f >= 8 && f <= 11))};
         n_checks++;
         if ({dout, rise, fall, busy} !== exp) begin
            n_fail++;
            $display("FAIL enable_accept_edge f%0d: dout/rise/fall/busy=%b required %b", f, {dout, rise, fall, busy}, exp);
         end
      end
      en = 1'b1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      n_checks++;
      if (glitch_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL enable_glitch: glitch_cnt=%0d required 1", glitch_cnt);
      end
`endif
   endtask

   task automatic test_random();
      int run_left = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (run_left == 0) begin
            din      = 1'($urandom_range(0, 1));
            run_left = int'($urandom_range(1, 9));
         end
         run_left--;
         en = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 599) == 0) begin
            #1 rst = 1'b0;
            #1 rst = 1'b1;
         end
         @(posedge clk); #1;
         n_checks++;
         if ({dout, rise, fall, busy} !== {m_dout, m_rise, m_fall, m_busy}) begin
            n_fail++;
            $display("FAIL random c%0d: dout/rise/fall/busy=%b required %b", c, {dout, rise, fall, busy}, {m_dout, m_rise, m_fall, m_busy});
         end
`ifdef DEBOUNCE_GLITCH_CNT_EN
         n_checks++;
         if (glitch_cnt !== 8'(m_glitch)) begin
            n_fail++;
            $display("FAIL random_glitch c%0d: glitch_cnt=%0d required %0d", c, glitch_cnt, m_glitch);
         end
`endif
      end
      en = 1'b1;
   endtask

`ifdef DEBOUNCE_GLITCH_CNT_EN
   task automatic test_saturation();
      din = 1'b0; en = 1'b1;
      repeat (12) @(negedge clk);
      for (int p = 0; p < 300; p++) begin
         for (int k = 0; k < 6; k++) begin
            @(negedge clk); din = 1'(k < 3);
         end
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (glitch_cnt !== 8'd255) begin
         n_fail++;
         $display("FAIL saturation: glitch_cnt=%0d required 255", glitch_cnt);
      end
      n_checks++;
      if (glitch_cnt !== 8'(m_glitch) || dout !== 1'b0) begin
         n_fail++;
         $display("FAIL saturation_model: glitch_cnt=%0d dout=%b required %0d and 0", glitch_cnt, dout, m_glitch);
      end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_clean_fall();
      test_bounce();
      test_clean_rise();
      test_enable();
      test_random();
`ifdef DEBOUNCE_GLITCH_CNT_EN
      test_saturation();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
